// File: rtl/light_sequencer.sv
// Programmable traffic-light phase sequencer.
// Cycles GREEN -> YELLOW -> RED with per-phase durations and produces the
// light inputs for the scp_079 game FSM. It also exposes the current phase and
// the number of cycles left in it, so a checker can compare them against the
// scp_079 timer. Hold, emergency force-red and single-shot/repeat operation
// are supported.
module light_sequencer #(
    parameter int unsigned TW       = 6,
    parameter int unsigned GREEN_T  = 25,
    parameter int unsigned YELLOW_T = 22,
    parameter int unsigned RED_T    = 29
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic          repeat_en,
    input  logic          hold,
    input  logic          force_red,
    output logic          green,
    output logic          yellow,
    output logic          red,
    output logic [1:0]    phase,
    output logic [TW-1:0] remaining,
    output logic          cycle_done
);

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_RED    = 2'd3
    } phase_e;

    // A zero duration would leave a phase with nothing to count down. It is
    // promoted to one cycle. Values wider than the counter saturate rather
    // than truncate, so a bad parameter can never alias to zero.
    function automatic logic [TW-1:0] clamp_dur(input int unsigned d);
        if (d == 0)
            return TW'(1);
        else if (d >= (32'd1 << TW))
            return '1;
        else
            return TW'(d);
    endfunction

    localparam logic [TW-1:0] G_LEN = clamp_dur(GREEN_T);
    localparam logic [TW-1:0] Y_LEN = clamp_dur(YELLOW_T);
    localparam logic [TW-1:0] R_LEN = clamp_dur(RED_T);

    phase_e        phase_q, phase_d;
    logic [TW-1:0] rem_q,   rem_d;
    logic          green_q, green_d;
    logic          yellow_q, yellow_d;
    logic          red_q,   red_d;

    // The last cycle of a phase is remaining==1. Treating 0 as "last" as well
    // means the counter can never underflow, even from an unexpected state.
    logic last_cycle;
    assign last_cycle = (rem_q <= TW'(1));

    // Next phase and count. Priority: force_red, then hold, then start, then
    // the normal countdown.
    always_comb begin
        phase_d = phase_q;
        rem_d   = rem_q;
        if (force_red) begin
            // Enter RED from any phase; if already in RED, reload to extend it.
            phase_d = PH_RED;
            rem_d   = R_LEN;
        end else if (phase_q == PH_IDLE) begin
            // hold has nothing to freeze in IDLE; only start matters here.
            if (start) begin
                phase_d = PH_GREEN;
                rem_d   = G_LEN;
            end
        end else if (hold) begin
            phase_d = phase_q;
            rem_d   = rem_q;
        end else if (last_cycle) begin
            unique case (phase_q)
                PH_GREEN: begin
                    phase_d = PH_YELLOW;
                    rem_d   = Y_LEN;
                end
                PH_YELLOW: begin
                    phase_d = PH_RED;
                    rem_d   = R_LEN;
                end
                PH_RED: begin
                    // repeat_en only matters on the edge that leaves RED.
                    if (repeat_en) begin
                        phase_d = PH_GREEN;
                        rem_d   = G_LEN;
                    end else begin
                        phase_d = PH_IDLE;
                        rem_d   = '0;
                    end
                end
                default: begin
                    phase_d = PH_IDLE;
                    rem_d   = '0;
                end
            endcase
        end else begin
            rem_d = rem_q - TW'(1);
        end
    end

    // The lights are decoded from the next phase and registered together with
    // it. They therefore switch on the same edge as phase and stay one-hot
    // with no decode glitches on the outputs.
    always_comb begin
        green_d  = (phase_d == PH_GREEN);
        yellow_d = (phase_d == PH_YELLOW);
        red_d    = (phase_d == PH_RED);
    end

    // State and registered light outputs. Reset is asynchronous and returns
    // the block to IDLE with all lights dark.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q  <= PH_IDLE;
            rem_q    <= '0;
            green_q  <= 1'b0;
            yellow_q <= 1'b0;
            red_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            rem_q    <= rem_d;
            green_q  <= green_d;
            yellow_q <= yellow_d;
            red_q    <= red_d;
        end
    end

    // End-of-cycle pulse: the final RED cycle, provided hold is not freezing it.
    // This is decoded from registered state, so it drops to zero as soon as
    // reset is asserted.
    always_comb begin
        cycle_done = (phase_q == PH_RED) && (rem_q == TW'(1)) && !hold;
    end

    assign green     = green_q;
    assign yellow    = yellow_q;
    assign red       = red_q;
    assign phase     = phase_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Bench for light_sequencer. It uses two instances on shared inputs: d0 with
// the default durations (25/22/29) and d1 with every duration set to 1.
// Checking combines:
//   - a table of single-cycle vectors with hand-computed expectations
//   - hand-written multi-cycle sequences
//   - a randomized run against a phase/count reference model
module tb_light_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       repeat_en = 1'b0;
    logic       hold = 1'b0;
    logic       force_red = 1'b0;

    logic       g0, y0, r0, cd0;
    logic [1:0] ph0;
    logic [5:0] rem0;
    logic       g1, y1, r1, cd1;
    logic [1:0] ph1;
    logic [5:0] rem1;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    light_sequencer #(.TW(6), .GREEN_T(25), .YELLOW_T(22), .RED_T(29)) d0 (
        .clock(clock), .reset_n(reset_n), .start(start), .repeat_en(repeat_en),
        .hold(hold), .force_red(force_red), .green(g0), .yellow(y0), .red(r0),
        .phase(ph0), .remaining(rem0), .cycle_done(cd0));

    light_sequencer #(.TW(6), .GREEN_T(1), .YELLOW_T(1), .RED_T(1)) d1 (
        .clock(clock), .reset_n(reset_n), .start(start), .repeat_en(repeat_en),
        .hold(hold), .force_red(force_red), .green(g1), .yellow(y1), .red(r1),
        .phase(ph1), .remaining(rem1), .cycle_done(cd1));

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit s, input bit r, input bit h, input bit f);
        start = s; repeat_en = r; hold = h; force_red = f;
    endtask

    // One clock: apply the edge, then settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        #1;
    endtask

    // Reference model: phase 0..3 plus a cycle count, stepped from the rules.
    int dur [2][4];
    int m_ph [2];
    int m_rem [2];

    function automatic bit model_done(input int i, input bit h);
        return (m_ph[i] == 3) && (m_rem[i] == 1) && !h;
    endfunction

    task automatic model_step(input int i, input bit s, input bit r, input bit h, input bit f);
        if (f) begin
            m_ph[i] = 3; m_rem[i] = dur[i][3];
        end else if (m_ph[i] == 0) begin
            if (s) begin m_ph[i] = 1; m_rem[i] = dur[i][1]; end
        end else if (h) begin
            // frozen
        end else if (m_rem[i] == 1) begin
            if (m_ph[i] == 3) begin
                if (r) begin m_ph[i] = 1; m_rem[i] = dur[i][1]; end
                else   begin m_ph[i] = 0; m_rem[i] = 0; end
            end else begin
                m_ph[i] = m_ph[i] + 1;
                m_rem[i] = dur[i][m_ph[i]];
            end
        end else begin
            m_rem[i] = m_rem[i] - 1;
        end
    endtask

    typedef struct {
        bit s, r, h, f;   // inputs for this cycle
        bit done;         // cycle_done before the edge
        int ph;           // phase after the edge
        int rem;          // remaining after the edge
    } vec_t;
    vec_t tbl [10];

    initial begin
        int k, gcnt, ycnt, rcnt, dcnt, ohbad;
        int didx [$];
        bit s, r, h, f;

        tbl[0] = '{0, 0, 0, 0, 0, 0, 0};   // idle stays idle
        tbl[1] = '{0, 0, 1, 0, 0, 0, 0};   // hold has no effect in IDLE
        tbl[2] = '{1, 0, 0, 0, 0, 1, 25};  // start -> GREEN full
        tbl[3] = '{0, 0, 0, 0, 0, 1, 24};  // countdown
        tbl[4] = '{1, 0, 0, 0, 0, 1, 23};  // start ignored in GREEN
        tbl[5] = '{0, 0, 1, 0, 0, 1, 23};  // hold freezes
        tbl[6] = '{0, 0, 1, 1, 0, 3, 29};  // force beats hold
        tbl[7] = '{0, 0, 0, 0, 0, 3, 28};
        tbl[8] = '{0, 0, 0, 1, 0, 3, 29};  // force in RED reloads
        tbl[9] = '{0, 0, 1, 0, 0, 3, 29};

        dur[0] = '{0, 25, 22, 29};
        dur[1] = '{0, 1, 1, 1};

        // Reset state, checked while reset is still asserted.
        #1;
        chk("rst_phase", ph0, 0);
        chk("rst_rem", rem0, 0);
        chk("rst_lights", {g0, y0, r0}, 0);
        chk("rst_done", cd0, 0);
        do_reset();

        // Vector table.
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].s, tbl[i].r, tbl[i].h, tbl[i].f);
            #1 chk($sformatf("tbl%0d_done", i), cd0, tbl[i].done);
            tick();
            chk($sformatf("tbl%0d_phase", i), ph0, tbl[i].ph);
            chk($sformatf("tbl%0d_rem", i), rem0, tbl[i].rem);
            chk($sformatf("tbl%0d_onehot", i), {g0, y0, r0},
                (tbl[i].ph == 0) ? 0 : (3'b100 >> (tbl[i].ph - 1)));
        end

        // Single shot: count how many cycles each light is on.
        do_reset();
        set_in(1, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0);
        gcnt = 0; ycnt = 0; rcnt = 0; dcnt = 0; ohbad = 0;
        for (k = 0; k < 200 && ph0 != 0; k++) begin
            gcnt += g0; ycnt += y0; rcnt += r0; dcnt += cd0;
            if (cd0 && !(r0 && rem0 == 1)) ohbad++;
            if (g0 + y0 + r0 > 1) ohbad++;
            tick();
        end
        chk("ss_green_len", gcnt, 25);
        chk("ss_yellow_len", ycnt, 22);
        chk("ss_red_len", rcnt, 29);
        chk("ss_done_count", dcnt, 1);
        chk("ss_bad", ohbad, 0);
        chk("ss_end_phase", ph0, 0);
        chk("ss_end_lights", {g0, y0, r0}, 0);

        // Repeat mode: cycle_done every 76 cycles, green right after red.
        do_reset();
        set_in(1, 1, 0, 0);
        tick();
        set_in(0, 1, 0, 0);
        for (k = 0; k < 160; k++) begin
            if (cd0) didx.push_back(k);
            if (k == 76) chk("rep_green_again", {g0, rem0}, {1'b1, 6'd25});
            tick();
        end
        chk("rep_pulses", didx.size(), 2);
        if (didx.size() >= 2) begin
            chk("rep_first", didx[0], 75);
            chk("rep_period", didx[1] - didx[0], 76);
        end

        // Hold at GREEN remaining=10.
        do_reset();
        set_in(1, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0);
        gcnt = 1;
        repeat (15) begin tick(); gcnt += g0; end
        chk("hold_pre_rem", rem0, 10);
        hold = 1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("hold_no_done", cd0, 0);
            tick();
            chk("hold_rem", rem0, 10);
            chk("hold_green", g0, 1);
            gcnt += g0;
        end
        hold = 0;
        for (k = 0; k < 40; k++) begin
            tick();
            if (!g0) break;
            gcnt++;
        end
        chk("hold_green_total", gcnt, 30);
        chk("hold_then_yellow", {y0, rem0}, {1'b1, 6'd22});

        // Force red from YELLOW rem=7, then again from RED rem=3.
        repeat (15) tick();
        chk("frc_pre", {y0, rem0}, {1'b1, 6'd7});
        force_red = 1;
        tick();
        force_red = 0;
        chk("frc_red", {r0, rem0}, {1'b1, 6'd29});
        repeat (26) tick();
        chk("frc_pre2", rem0, 3);
        force_red = 1;
        tick();
        force_red = 0;
        chk("frc_reload", {r0, rem0}, {1'b1, 6'd29});

        // Asynchronous reset between edges while in RED.
        #3 reset_n = 1'b0;
        #1;
        chk("arst_phase", ph0, 0);
        chk("arst_lights", {g0, y0, r0}, 0);
        chk("arst_rem", rem0, 0);
        chk("arst_done", cd0, 0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        #1;
        dcnt = 0;
        repeat (3) begin tick(); dcnt += ph0 + cd0; end
        chk("arst_needs_start", dcnt, 0);

        // All durations 1: rotates every cycle, done every third cycle.
        do_reset();
        set_in(1, 1, 0, 0);
        tick();
        set_in(0, 1, 0, 0);
        ohbad = 0; dcnt = 0;
        for (k = 0; k < 12; k++) begin
            chk("fast_phase", ph1, (k % 3) + 1);
            chk("fast_done", cd1, (k % 3) == 2);
            if ((g1 + y1 + r1) != 1) ohbad++;
            tick();
        end
        chk("fast_onehot", ohbad, 0);

        // Randomized inputs against the reference model, on both instances.
        do_reset();
        for (int i = 0; i < 2; i++) begin m_ph[i] = 0; m_rem[i] = 0; end
        r = 0;
        for (int c = 0; c < 3000; c++) begin
            s = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) r = ~r;
            h = ($urandom_range(0, 5) == 0);
            f = ($urandom_range(0, 39) == 0);
            set_in(s, r, h, f);
            #1;
            chk("rnd_done0", cd0, model_done(0, h));
            chk("rnd_done1", cd1, model_done(1, h));
            for (int i = 0; i < 2; i++) model_step(i, s, r, h, f);
            tick();
            chk("rnd_phase0", ph0, m_ph[0]);
            chk("rnd_rem0", rem0, m_rem[0]);
            chk("rnd_lights0", {g0, y0, r0}, {m_ph[0] == 1, m_ph[0] == 2, m_ph[0] == 3});
            chk("rnd_phase1", ph1, m_ph[1]);
            chk("rnd_rem1", rem1, m_rem[1]);
            chk("rnd_lights1", {g1, y1, r1}, {m_ph[1] == 1, m_ph[1] == 2, m_ph[1] == 3});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
